wbu_stage: RTL and testbench

Registered, handshaked write-back stage for the RV32 core. It replaces the purely combinational write-back path.
- Accepts one retiring instruction from EXU/LSU.
- Waits for the load response when needed.
- Aligns and sign/zero-extends load data.
- Selects among ALU, MEM, PC+4 and CSR sources.
- Issues a single-cycle GPR write plus a commit pulse carrying the next PC to IFU.
- Keeps a retired-instruction counter.

---
 rtl/wbu_stage_pkg.sv | 37 +++
 rtl/wbu_stage_load_align.sv | 39 +++
 rtl/wbu_stage.sv | 166 ++++++++++++++++
 tb/tb_wbu_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wbu_stage_pkg.sv
// Shared write-back definitions: source-select and load-format encodings,
// FSM state type and core-wide defaults.
package wbu_stage_pkg;

  localparam int unsigned WBU_XLEN = 32;
  localparam logic [31:0] WBU_RESET_PC = 32'h8000_0000;

  localparam logic [1:0] REGS_ALU = 2'd0;
  localparam logic [1:0] REGS_MEM = 2'd1;
  localparam logic [1:0] REGS_PC4 = 2'd2;
  localparam logic [1:0] REGS_CSR = 2'd3;

  localparam logic [1:0] LD_BYTE = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_WORD = 2'd2;
  localparam logic [1:0] LD_RSVD = 2'd3;
  localparam int unsigned LD_UNSIGNED_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_COMMIT   = 2'd2
  } wbu_state_e;

  // Extend a byte or halfword lane to 32 bits, signed unless zext is set.
  function automatic logic [31:0] extend_lane(input logic [15:0] lane, input logic is_half,
                                              input logic zext);
    logic [31:0] value;
    if (is_half) begin
      value = {{16{lane[15] & ~zext}}, lane};
    end else begin
      value = {{24{lane[7] & ~zext}}, lane[7:0]};
    end
    return value;
  endfunction

endpackage

// File: rtl/wbu_stage_load_align.sv
// Combinational load aligner: picks the byte/half lane addressed by off
// from a raw aligned word and sign- or zero-extends it.
module wbu_stage_load_align
  import wbu_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  fmt,
  output logic [31:0] value
);

  logic [7:0]  byte_lane_s;
  logic [15:0] half_lane_s;

  // Lane selection and extension by load size.
  always_comb begin
    byte_lane_s = 8'd0;
    half_lane_s = 16'd0;
    value       = word;
    case (off)
      2'd0:    byte_lane_s = word[7:0];
      2'd1:    byte_lane_s = word[15:8];
      2'd2:    byte_lane_s = word[23:16];
      default: byte_lane_s = word[31:24];
    endcase
    if (off[1]) begin
      half_lane_s = word[31:16];
    end else begin
      half_lane_s = word[15:0];
    end
    case (fmt[1:0])
      LD_BYTE: value = extend_lane({8'd0, byte_lane_s}, 1'b0, fmt[LD_UNSIGNED_BIT]);
      LD_HALF: value = extend_lane(half_lane_s, 1'b1, fmt[LD_UNSIGNED_BIT]);
      LD_WORD: value = word;
      default: value = word;
    endcase
  end

endmodule

// File: rtl/wbu_stage.sv
// Registered, handshaked write-back stage: latches one retiring instruction,
// waits for load data when needed, then commits a GPR write and next PC.
module wbu_stage
  import wbu_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = WBU_XLEN,
  parameter int unsigned     REG_AW   = 5,
  parameter logic [XLEN-1:0] RESET_PC = WBU_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_dnpc,
  input  logic [XLEN-1:0]   in_result,
  input  logic [XLEN-1:0]   in_csr_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_regs,
  input  logic              in_regw,
  input  logic [2:0]        in_ldfmt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              gpr_wen,
  output logic [REG_AW-1:0] gpr_waddr,
  output logic [XLEN-1:0]   gpr_wdata,
  output logic              commit_valid,
  output logic [XLEN-1:0]   commit_pc,
  output logic [XLEN-1:0]   commit_dnpc,
  output logic [63:0]       retire_cnt
);

  wbu_state_e        state_r, state_nxt_s;
  logic [XLEN-1:0]   pc_r, dnpc_r, result_r, csr_r, rdata_r;
  logic [REG_AW-1:0] rd_r, rd_nxt_s;
  logic [1:0]        regs_r;
  logic              regw_r, regw_nxt_s;
  logic [2:0]        ldfmt_r;
  logic [XLEN-1:0]   dnpc_nxt_s, align_s, wdata_s;
  logic              accept_s, commit_enter_s;
  logic              commit_valid_r, gpr_wen_r;
  logic [XLEN-1:0]   commit_dnpc_r;
  logic [63:0]       retire_cnt_r;

  assign in_ready       = (state_r != ST_WAIT_MEM);
  assign accept_s       = in_valid && in_ready;
  assign commit_enter_s = (state_nxt_s == ST_COMMIT);

  // Next-state logic; COMMIT can chain straight into a new instruction.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_COMMIT: begin
        if (accept_s) begin
          if (in_regs == REGS_MEM) begin
            state_nxt_s = ST_WAIT_MEM;
          end else begin
            state_nxt_s = ST_COMMIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_nxt_s = ST_COMMIT;
        end else begin
          state_nxt_s = ST_WAIT_MEM;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Fields of the instruction about to commit, so commit outputs can be registered.
  always_comb begin
    regw_nxt_s = regw_r;
    rd_nxt_s   = rd_r;
    dnpc_nxt_s = dnpc_r;
    if (accept_s) begin
      regw_nxt_s = in_regw;
      rd_nxt_s   = in_rd;
      dnpc_nxt_s = in_dnpc;
    end else begin
      regw_nxt_s = regw_r;
      rd_nxt_s   = rd_r;
      dnpc_nxt_s = dnpc_r;
    end
  end

  wbu_stage_load_align u_load_align (
    .word  (rdata_r),
    .off   (result_r[1:0]),
    .fmt   (ldfmt_r),
    .value (align_s)
  );

  // Write-data source select on the latched fields.
  always_comb begin
    wdata_s = result_r;
    case (regs_r)
      REGS_ALU: wdata_s = result_r;
      REGS_MEM: wdata_s = align_s;
      REGS_PC4: wdata_s = pc_r + XLEN'(3'd4);
      REGS_CSR: wdata_s = csr_r;
      default:  wdata_s = result_r;
    endcase
  end

  // State register and instruction latch; load data only captured in WAIT_MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      pc_r     <= {XLEN{1'b0}};
      dnpc_r   <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
      csr_r    <= {XLEN{1'b0}};
      rdata_r  <= {XLEN{1'b0}};
      rd_r     <= {REG_AW{1'b0}};
      regs_r   <= REGS_ALU;
      regw_r   <= 1'b0;
      ldfmt_r  <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        pc_r     <= in_pc;
        dnpc_r   <= in_dnpc;
        result_r <= in_result;
        csr_r    <= in_csr_data;
        rd_r     <= in_rd;
        regs_r   <= in_regs;
        regw_r   <= in_regw;
        ldfmt_r  <= in_ldfmt;
      end
      if ((state_r == ST_WAIT_MEM) && mem_rvalid) begin
        rdata_r <= mem_rdata;
      end
    end
  end

  // Commit strobes, next-PC and retire counter, loaded on entry to COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid_r <= 1'b0;
      gpr_wen_r      <= 1'b0;
      commit_dnpc_r  <= RESET_PC;
      retire_cnt_r   <= 64'd0;
    end else begin
      commit_valid_r <= commit_enter_s;
      gpr_wen_r      <= commit_enter_s && regw_nxt_s && (rd_nxt_s != {REG_AW{1'b0}});
      if (commit_enter_s) begin
        commit_dnpc_r <= dnpc_nxt_s;
        retire_cnt_r  <= retire_cnt_r + 64'd1;
      end
    end
  end

  assign commit_valid = commit_valid_r;
  assign gpr_wen      = gpr_wen_r;
  assign gpr_waddr    = rd_r;
  assign gpr_wdata    = wdata_s;
  assign commit_pc    = pc_r;
  assign commit_dnpc  = commit_dnpc_r;
  assign retire_cnt   = retire_cnt_r;

endmodule

// File: tb/tb_wbu_stage.sv
// Scoreboard bench for wbu_stage: a driver pushes expected commits computed
// by a reference model, a negedge monitor pops and compares them.
module tb_wbu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = 32'd0, in_dnpc = 32'd0, in_result = 32'd0, in_csr_data = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [1:0]  in_regs = 2'd0;
  logic        in_regw = 1'b0;
  logic [2:0]  in_ldfmt = 3'd0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc, commit_dnpc;
  logic [63:0] retire_cnt;

  wbu_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_dnpc(in_dnpc), .in_result(in_result), .in_csr_data(in_csr_data),
    .in_rd(in_rd), .in_regs(in_regs), .in_regw(in_regw), .in_ldfmt(in_ldfmt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_dnpc(commit_dnpc),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] dnpc;
    logic [63:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_cnt = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what the write-back value should be, from the ISA rules.
  function automatic logic [31:0] model_wdata(input logic [1:0] regs, input logic [31:0] pc,
      input logic [31:0] result, input logic [31:0] csr, input logic [2:0] fmt,
      input logic [31:0] rdata);
    int unsigned off;
    logic [31:0] v;
    off = result & 32'd3;
    v = 32'd0;
    if (regs == 2'd0) v = result;
    else if (regs == 2'd2) v = pc + 32'd4;
    else if (regs == 2'd3) v = csr;
    else begin
      if ((fmt & 3'd3) == 3'd0) begin
        v = (rdata >> (8 * off)) & 32'hFF;
        if (fmt < 3'd4 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if ((fmt & 3'd3) == 3'd1) begin
        v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        if (fmt < 3'd4 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
        v = rdata;
      end
    end
    return v;
  endfunction

  task automatic push_exp(input int c, input logic regw, input logic [4:0] rd,
                          input logic [31:0] wdata, input logic [31:0] pc, input logic [31:0] dnpc);
    exp_t e;
    exp_cnt = exp_cnt + 64'd1;
    e.cyc = c; e.wen = regw && (rd != 5'd0); e.waddr = rd; e.wdata = wdata;
    e.pc = pc; e.dnpc = dnpc; e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Issue one instruction; loads get their response dly cycles after accept.
  task automatic issue(input logic [31:0] pc, input logic [31:0] dnpc, input logic [31:0] result,
                       input logic [31:0] csr, input logic [4:0] rd, input logic [1:0] regs,
                       input logic regw, input logic [2:0] fmt, input logic [31:0] rdata,
                       input int dly, input bit stray);
    logic [31:0] wd;
    in_valid = 1'b1; in_pc = pc; in_dnpc = dnpc; in_result = result; in_csr_data = csr;
    in_rd = rd; in_regs = regs; in_regw = regw; in_ldfmt = fmt;
    mem_rvalid = stray; mem_rdata = ~rdata;
    @(negedge clk);
    chk("in_ready_accept", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    wd = model_wdata(regs, pc, result, csr, fmt, rdata);
    if (regs != 2'd1) begin
      push_exp(cyc, regw, rd, wd, pc, dnpc);
    end else begin
      in_valid = 1'b0;
      repeat (dly) begin
        @(negedge clk);
        chk("in_ready_wait", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      chk("in_ready_wait", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      push_exp(cyc, regw, rd, wd, pc, dnpc);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_commit_valid"}, {63'd0, commit_valid}, 64'd0);
    chk({tag, "_gpr_wen"}, {63'd0, gpr_wen}, 64'd0);
    chk({tag, "_gpr_waddr"}, {59'd0, gpr_waddr}, 64'd0);
    chk({tag, "_gpr_wdata"}, {32'd0, gpr_wdata}, 64'd0);
    chk({tag, "_commit_pc"}, {32'd0, commit_pc}, 64'd0);
    chk({tag, "_commit_dnpc"}, {32'd0, commit_dnpc}, 64'h8000_0000);
    chk({tag, "_retire_cnt"}, retire_cnt, 64'd0);
  endtask

  // Monitor: every commit must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (commit_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit: got commit pc=%0h expected none (cycle %0d)",
                   commit_pc, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("commit_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("gpr_wen", {63'd0, gpr_wen}, {63'd0, mon_e.wen});
          chk("gpr_waddr", {59'd0, gpr_waddr}, {59'd0, mon_e.waddr});
          chk("gpr_wdata", {32'd0, gpr_wdata}, {32'd0, mon_e.wdata});
          chk("commit_pc", {32'd0, commit_pc}, {32'd0, mon_e.pc});
          chk("commit_dnpc", {32'd0, commit_dnpc}, {32'd0, mon_e.dnpc});
          chk("retire_cnt", retire_cnt, mon_e.cnt);
        end
      end else begin
        chk("gpr_wen_idle", {63'd0, gpr_wen}, 64'd0);
      end
    end
  end

  initial begin
    logic [1:0] r;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1;

    issue(32'h8000_0000, 32'h8000_0004, 32'h0000_1234, 32'd0, 5'd5, 2'd0, 1'b1, 3'd0, 32'd0, 0, 1'b0);
    idle(2);
    issue(32'h8000_0004, 32'h8000_0008, 32'h1000_0002, 32'd0, 5'd6, 2'd1, 1'b1, 3'b000, 32'h0080_0000, 3, 1'b0);
    issue(32'h8000_0008, 32'h8000_000C, 32'h1000_0002, 32'd0, 5'd7, 2'd1, 1'b1, 3'b100, 32'h0080_0000, 3, 1'b1);
    issue(32'h8000_000C, 32'h8000_0010, 32'h1000_0003, 32'd0, 5'd8, 2'd1, 1'b1, 3'b001, 32'h8001_0000, 1, 1'b0);
    idle(1);
    issue(32'h8000_0010, 32'h8000_0014, 32'h0000_0011, 32'd0, 5'd1, 2'd0, 1'b1, 3'd0, 32'd0, 0, 1'b0);
    issue(32'h8000_0014, 32'h8000_0018, 32'h0000_0022, 32'd0, 5'd2, 2'd0, 1'b1, 3'd0, 32'd0, 0, 1'b0);
    issue(32'h8000_0018, 32'h8000_001C, 32'h0000_0033, 32'd0, 5'd3, 2'd0, 1'b1, 3'd0, 32'd0, 0, 1'b0);
    issue(32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0044, 32'd0, 5'd9, 2'd2, 1'b1, 3'd0, 32'd0, 0, 1'b0);
    issue(32'h8000_0020, 32'h8000_0024, 32'h0000_0055, 32'd0, 5'd0, 2'd0, 1'b1, 3'd0, 32'd0, 0, 1'b0);
    issue(32'h8000_0024, 32'h8000_0028, 32'h0000_0066, 32'hDEAD_BEEF, 5'd10, 2'd3, 1'b1, 3'd0, 32'h1111_2222, 0, 1'b1);
    idle(2);

    // Reset while waiting for load data; the late response must be ignored.
    in_valid = 1'b1; in_regs = 2'd1; in_rd = 5'd4; in_regw = 1'b1;
    in_pc = 32'h8000_0100; in_dnpc = 32'h8000_0104; in_result = 32'h0000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 64'd0;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    chk_reset_state("midload_reset");
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    idle(3);
    @(negedge clk);
    chk("post_reset_retire_cnt", retire_cnt, 64'd0);
    chk("post_reset_dnpc", {32'd0, commit_dnpc}, 64'h8000_0000);
    @(posedge clk); #1;

    for (int i = 0; i < 200; i++) begin
      r = 2'($urandom_range(3, 0));
      issue(($urandom_range(9, 0) == 0) ? 32'hFFFF_FFFC : $urandom, $urandom, $urandom, $urandom,
            5'($urandom_range(31, 0)), r, 1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
            $urandom, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
      if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 1));
    end
    idle(5);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
